// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the byte-serial add/subtract sequencer.
package adder_seq_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned NBYTES_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/adder8_cin.sv
// 8-bit combinational ripple adder with carry-in/carry-out, built from two 4-bit stages.
module adder8_cin
  import adder_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] s,
  output logic              cout
);

  logic [4:0] w_lo;
  logic [4:0] w_hi;

  assign w_lo = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
  assign w_hi = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, w_lo[4]};

  assign s    = {w_hi[3:0], w_lo[3:0]};
  assign cout = w_hi[4];

endmodule

// File: rtl/adder_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one shared 8-bit slice, one byte per clock, LSB first.
// Optional signed-overflow output is enabled with ADDSEQ_OVF_EN.
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int unsigned NBYTES = NBYTES_DEFAULT,
  localparam int unsigned W     = BYTE_W * NBYTES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         c_out
`ifdef ADDSEQ_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned    IdxW    = $clog2(NBYTES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

  state_e            r_state;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic              r_sub;
  logic              r_carry;
  logic [IdxW-1:0]   r_idx;

  logic [BYTE_W-1:0] w_a_byte;
  logic [BYTE_W-1:0] w_b_byte;
  logic [BYTE_W-1:0] w_sum_byte;
  logic              w_cout;

  // Subtraction is a + ~b + 1; the +1 comes from seeding the carry with sub.
  assign w_a_byte = r_a[r_idx*BYTE_W +: BYTE_W];
  assign w_b_byte = r_b[r_idx*BYTE_W +: BYTE_W] ^ {BYTE_W{r_sub}};

  adder8_cin u_adder8_cin (
    .a    (w_a_byte),
    .b    (w_b_byte),
    .cin  (r_carry),
    .s    (w_sum_byte),
    .cout (w_cout)
  );

`ifdef ADDSEQ_OVF_EN
  logic w_ovf;
  // Carry into the MSB is recovered from the MSB sum bit.
  assign w_ovf = (w_a_byte[BYTE_W-1] ^ w_b_byte[BYTE_W-1] ^ w_sum_byte[BYTE_W-1]) ^ w_cout;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
`ifdef ADDSEQ_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_sub   <= sub;
            r_carry <= sub;
            r_idx   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          sum[r_idx*BYTE_W +: BYTE_W] <= w_sum_byte;
          r_carry                     <= w_cout;
          if (r_idx == LastIdx) begin
            c_out   <= w_cout;
`ifdef ADDSEQ_OVF_EN
            ovf     <= w_ovf;
`endif
            done    <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + IdxW'(1);
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl: directed, random, back-to-back and reset-abort scenarios.
module tb_adder_seq_ctrl;

  localparam int unsigned NBYTES = 4;
  localparam int unsigned W      = 8 * NBYTES;
  localparam int unsigned PERIOD = NBYTES + 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef ADDSEQ_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_seq_ctrl #(.NBYTES(NBYTES)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
`ifdef ADDSEQ_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  // Reference: {ovf, c_out, sum} from plain W-bit arithmetic.
  function automatic logic [W+1:0] model(input logic s, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    logic [W:0] r;
    logic       ov;
    if (!s) begin
      r  = {1'b0, x} + {1'b0, y};
      ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      r[W-1:0] = x - y;
      r[W]     = (x >= y);
      ov       = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end
    return {ov, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++;
    if ({busy, done, c_out} !== 3'b000 || sum !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b c_out=%b sum=%h, required all 0",
               busy, done, c_out, sum);
    end
`ifdef ADDSEQ_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: ovf=%b, required 0", ovf);
    end
`endif
    reset = 1'b0;
    tick();
  endtask

  // One operation from IDLE; operands are scrambled after acceptance to prove latching.
  task automatic do_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                       input string name);
    logic [W+1:0] exp;
    int           lat;
    exp   = model(s, x, y);
    start = 1'b1;
    sub   = s;
    a     = x;
    b     = y;
    tick();
    lat   = 1;
    start = 1'b0;
    sub   = 1'($urandom);
    a     = $urandom;
    b     = $urandom;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_accept: busy=%b, required 1", name, busy);
    end
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != NBYTES + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, lat, NBYTES + 1);
    end
    checks++;
    if (sum !== exp[W-1:0] || c_out !== exp[W]) begin
      errors++;
      $display("FAIL %s result: sum=%h c_out=%b, required sum=%h c_out=%b",
               name, sum, c_out, exp[W-1:0], exp[W]);
    end
`ifdef ADDSEQ_OVF_EN
    checks++;
    if (ovf !== exp[W+1]) begin
      errors++;
      $display("FAIL %s ovf: got %b, required %b", name, ovf, exp[W+1]);
    end
`endif
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_end: done=%b busy=%b, required 0 0", name, done, busy);
    end
  endtask

  task automatic test_directed();
    do_op(1'b0, 32'h0000_00FF, 32'h0000_0001, "add_ff_1");
    do_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, "add_wrap");
    do_op(1'b1, 32'h0000_0005, 32'h0000_0007, "sub_5_7");
    do_op(1'b1, 32'h0000_0007, 32'h0000_0005, "sub_7_5");
    do_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, "add_sovf");
    do_op(1'b1, 32'h8000_0000, 32'h0000_0001, "sub_sovf");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      do_op(1'($urandom), $urandom, $urandom, "random");
    end
  endtask

  // start held high; acceptance happens every PERIOD edges, at the edges where k % PERIOD == 0.
  task automatic test_back_to_back();
    logic [W-1:0] ta[30];
    logic [W-1:0] tb[30];
    logic         ts[30];
    logic [W+1:0] exp;
    int           ph;
    for (int k = 0; k < 30; k++) begin
      ta[k] = $urandom;
      tb[k] = $urandom;
      ts[k] = 1'($urandom);
      start = 1'b1;
      a     = ta[k];
      b     = tb[k];
      sub   = ts[k];
      tick();
      ph = k % PERIOD;
      checks++;
      if (done !== (ph == NBYTES) || busy !== (ph != NBYTES + 1)) begin
        errors++;
        $display("FAIL b2b_handshake k=%0d: done=%b busy=%b, required %b %b",
                 k, done, busy, ph == NBYTES, ph != NBYTES + 1);
      end
      if (ph == NBYTES) begin
        exp = model(ts[k-NBYTES], ta[k-NBYTES], tb[k-NBYTES]);
        checks++;
        if (sum !== exp[W-1:0] || c_out !== exp[W]) begin
          errors++;
          $display("FAIL b2b_result k=%0d: sum=%h c_out=%b, required sum=%h c_out=%b",
                   k, sum, c_out, exp[W-1:0], exp[W]);
        end
      end
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    start = 1'b1;
    sub   = 1'b0;
    a     = 32'hFFFF_FFFF;
    b     = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, c_out} !== 3'b000 || sum !== '0) begin
      errors++;
      $display("FAIL abort_state: busy=%b done=%b c_out=%b sum=%h, required all 0",
               busy, done, c_out, sum);
    end
`ifdef ADDSEQ_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL abort_ovf: ovf=%b, required 0", ovf);
    end
`endif
    pulses = 0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || sum !== '0) begin
      errors++;
      $display("FAIL abort_no_done: pulses=%0d sum=%h, required 0 pulses sum=0", pulses, sum);
    end
    do_op(1'b0, 32'h0000_0003, 32'h0000_0004, "after_abort");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
